// File: rtl/afe_ro_buf_ctrl_pkg.sv
// Shared types for the AFE readout ring-buffer controller.
package afe_ro_buf_ctrl_pkg;

    // Output FIFO entries plus in-flight reads may never exceed this.
    localparam int unsigned OUT_CREDITS = 2;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_WRITE,
        ACC_READ
    } acc_e;

endpackage

// File: rtl/afe_ro_buf_ctrl_out_fifo.sv
// Two-entry valid/ready FIFO; entry q0 is always the head.
module afe_ro_out_fifo #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] q0;
    logic [DATA_WIDTH-1:0] q1;

    // NOTE: storage is reset as well so the head reads 0 after reset rather than X.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ <= 2'd0;
            q0  <= '0;
            q1  <= '0;
        end else if (clr) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) q0 <= wdata;
                    else             q1 <= wdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    q0  <= q1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        q0 <= wdata;
                    end else begin
                        q0 <= q1;
                        q1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (occ != 2'd0);
    assign rdata = q0;

endmodule

// File: rtl/afe_ro_buf_ctrl.sv
// Ring-buffer controller owning the single SRAM port of the AFE sample buffer;
// writes have priority, idle cycles prefetch into a 2-entry output FIFO.
module afe_ro_buf_ctrl
    import afe_ro_buf_ctrl_pkg::*;
#(
    parameter int unsigned AFE_DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH     = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic [ADDR_WIDTH:0]       thr_i,
    input  logic                      afe_valid_i,
    input  logic [AFE_DATA_WIDTH-1:0] afe_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [AFE_DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH:0]       fill_o,
    output logic                      ovf_o,
    output logic                      thr_evt_o,
    output logic                      sram_cen_o,
    output logic                      sram_wen_o,
    output logic [ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [AFE_DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [AFE_DATA_WIDTH-1:0] sram_rdata_i
);

    localparam logic [ADDR_WIDTH:0] FILL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0]     wptr_q;
    logic [ADDR_WIDTH-1:0]     rptr_q;
    logic [ADDR_WIDTH:0]       fill_q;
    logic                      inflight_q;
    logic                      ovf_q;
    logic                      ge_q;
    logic                      evt_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [AFE_DATA_WIDTH-1:0] wdata_q;

    acc_e       acc;
    logic       drop;
    logic       fill_ge;
    logic       credits_ok;
    logic [2:0] credits_used;
    logic [1:0] fifo_occ;
    logic       fifo_push;
    logic       fifo_pop;

    assign credits_used = {1'b0, fifo_occ} + {2'b00, inflight_q};
    assign credits_ok   = credits_used < 3'(OUT_CREDITS);
    assign fill_ge      = fill_q >= thr_i;
    assign drop         = afe_valid_i & ~clr_i & (fill_q == FILL_FULL);

    // A cycle carrying a sample is never a free cycle, even when the sample is dropped.
    // NOTE: acc gets its default before any branch so no latch is inferred.
    always_comb begin
        acc = ACC_IDLE;
        if (!clr_i) begin
            if (afe_valid_i) begin
                if (fill_q != FILL_FULL) acc = ACC_WRITE;
            end else if ((fill_q != '0) && credits_ok) begin
                acc = ACC_READ;
            end
        end
    end

    always_comb begin
        sram_cen_o   = (acc == ACC_IDLE);
        sram_wen_o   = (acc != ACC_WRITE);
        sram_addr_o  = addr_q;
        sram_wdata_o = wdata_q;
        case (acc)
            ACC_WRITE: begin
                sram_addr_o  = wptr_q;
                sram_wdata_o = afe_data_i;
            end
            ACC_READ: sram_addr_o = rptr_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            inflight_q <= 1'b0;
            ovf_q      <= 1'b0;
            ge_q       <= 1'b0;
            evt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            addr_q     <= sram_addr_o;
            wdata_q    <= sram_wdata_o;
            inflight_q <= (acc == ACC_READ);
            if (clr_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                fill_q <= '0;
                ovf_q  <= 1'b0;
                ge_q   <= 1'b0;
                evt_q  <= 1'b0;
            end else begin
                ge_q  <= fill_ge;
                evt_q <= fill_ge & ~ge_q;
                if (drop) ovf_q <= 1'b1;
                case (acc)
                    ACC_WRITE: begin
                        wptr_q <= wptr_q + 1'b1;
                        fill_q <= fill_q + 1'b1;
                    end
                    ACC_READ: begin
                        rptr_q <= rptr_q + 1'b1;
                        fill_q <= fill_q - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data returns one cycle after the access; a flush discards it.
    assign fifo_push = inflight_q & ~clr_i;
    assign fifo_pop  = out_valid_o & out_ready_i;

    afe_ro_out_fifo #(
        .DATA_WIDTH (AFE_DATA_WIDTH)
    ) u_out_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (clr_i),
        .push   (fifo_push),
        .wdata  (sram_rdata_i),
        .pop    (fifo_pop),
        .valid  (out_valid_o),
        .rdata  (out_data_o),
        .occ    (fifo_occ)
    );

    assign fill_o    = fill_q;
    assign ovf_o     = ovf_q;
    assign thr_evt_o = evt_q;

endmodule

// File: tb/tb_afe_ro_buf_ctrl.sv
// Scoreboard bench for afe_ro_buf_ctrl with a small (depth 8) buffer and an SRAM model.
module tb_afe_ro_buf_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clr_i;
    logic [AW:0]   thr_i;
    logic          afe_valid_i;
    logic [DW-1:0] afe_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [AW:0]   fill_o;
    logic          ovf_o;
    logic          thr_evt_o;
    logic          sram_cen_o;
    logic          sram_wen_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [DW-1:0] sram_rdata_i;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    int waddr_exp = 0;
    int raddr_exp = 0;

    always #5 clk_i = ~clk_i;

    afe_ro_buf_ctrl #(
        .AFE_DATA_WIDTH (DW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .thr_i        (thr_i),
        .afe_valid_i  (afe_valid_i),
        .afe_data_i   (afe_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .fill_o       (fill_o),
        .ovf_o        (ovf_o),
        .thr_evt_o    (thr_evt_o),
        .sram_cen_o   (sram_cen_o),
        .sram_wen_o   (sram_wen_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    // Single-port SRAM model: read data appears the cycle after the access.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_i) begin
        if (!sram_cen_o) begin
            if (!sram_wen_o) mem[sram_addr_o] <= sram_wdata_o;
            else             sram_rdata_i     <= mem[sram_addr_o];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name);
        out_ready_i = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    // Output monitor: every accepted output sample must be the oldest stored sample.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", out_data_o, 0);
                tests++;
                fails++;
                $display("FAIL out_unexpected: got sample %0h expected none", out_data_o);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("out_data", out_data_o, e);
            end
        end
    end

    // Address monitor: accepted writes and reads each walk the ring in order.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (clr_i) begin
                waddr_exp = 0;
                raddr_exp = 0;
            end else if (!sram_cen_o) begin
                if (!sram_wen_o) begin
                    check("waddr", sram_addr_o, waddr_exp % DEPTH);
                    waddr_exp++;
                end else begin
                    check("raddr", sram_addr_o, raddr_exp % DEPTH);
                    raddr_exp++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        rst_ni      = 1'b0;
        clr_i       = 1'b0;
        thr_i       = 4'd15;
        afe_valid_i = 1'b0;
        afe_data_i  = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        @(negedge clk_i);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_fill", fill_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_thr_evt", thr_evt_o, 0);
        check("rst_cen", sram_cen_o, 1);
        check("rst_wen", sram_wen_o, 1);
        check("rst_addr", sram_addr_o, 0);
        check("rst_wdata", sram_wdata_o, 0);

        // Single sample into an empty buffer: write, read, capture, present.
        step();
        out_ready_i = 1'b1;
        afe_valid_i = 1'b1;
        afe_data_i  = 32'hA5;
        exp_q.push_back(32'hA5);
        @(negedge clk_i);
        check("lat_wr_cen", sram_cen_o, 0);
        check("lat_wr_wen", sram_wen_o, 0);
        check("lat_wr_wdata", sram_wdata_o, 32'hA5);
        step();
        afe_valid_i = 1'b0;
        @(negedge clk_i);
        check("lat_rd_cen", sram_cen_o, 0);
        check("lat_rd_wen", sram_wen_o, 1);
        check("lat_fill1", fill_o, 1);
        step();
        @(negedge clk_i);
        check("lat_not_yet", out_valid_o, 0);
        check("lat_fill0", fill_o, 0);
        step();
        @(negedge clk_i);
        check("lat_valid", out_valid_o, 1);
        check("lat_data", out_data_o, 32'hA5);
        drain("lat_drain");

        // Fill to full back to back, then a ninth sample that must be dropped.
        step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            afe_valid_i = 1'b1;
            afe_data_i  = DW'(i);
            if (i < DEPTH) exp_q.push_back(DW'(i));
            step();
        end
        afe_valid_i = 1'b0;
        @(negedge clk_i);
        check("ovf_set", ovf_o, 1);
        check("ovf_fill_full", fill_o, DEPTH);
        repeat (6) step();
        @(negedge clk_i);
        check("ovf_prefetch_fill", fill_o, DEPTH - 2);
        check("ovf_head_valid", out_valid_o, 1);
        check("ovf_head_data", out_data_o, 0);
        drain("ovf_drain");
        check("ovf_sticky", ovf_o, 1);
        step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        @(negedge clk_i);
        check("ovf_cleared", ovf_o, 0);

        // Watermark: one pulse the cycle after fill reaches the threshold.
        step();
        thr_i       = 4'd4;
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            afe_valid_i = 1'b1;
            afe_data_i  = DW'(100 + i);
            exp_q.push_back(DW'(100 + i));
            step();
        end
        afe_valid_i = 1'b0;
        @(negedge clk_i);
        check("thr_fill4", fill_o, 4);
        check("thr_not_yet", thr_evt_o, 0);
        step();
        @(negedge clk_i);
        check("thr_pulse", thr_evt_o, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk_i);
            check("thr_single", thr_evt_o, 0);
        end
        thr_i = 4'd15;
        drain("thr_drain");

        // Flush coinciding with a new sample and a read return.
        step();
        out_ready_i = 1'b0;
        afe_valid_i = 1'b1;
        afe_data_i  = 32'h77;
        exp_q.push_back(32'h77);
        step();
        afe_valid_i = 1'b0;
        step();
        clr_i       = 1'b1;
        afe_valid_i = 1'b1;
        afe_data_i  = 32'h88;
        exp_q.delete();
        @(negedge clk_i);
        check("clr_no_access", sram_cen_o, 1);
        step();
        clr_i       = 1'b0;
        afe_valid_i = 1'b0;
        @(negedge clk_i);
        check("clr_fill", fill_o, 0);
        check("clr_out_valid", out_valid_o, 0);
        check("clr_ovf", ovf_o, 0);
        out_ready_i = 1'b1;
        repeat (4) step();
        @(negedge clk_i);
        check("clr_stays_empty", out_valid_o, 0);

        // Wrap-around: 20 samples with random gaps through the 8-deep ring.
        for (int i = 0; i < 20; i++) begin
            afe_valid_i = 1'b1;
            afe_data_i  = $urandom;
            exp_q.push_back(afe_data_i);
            step();
            afe_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        drain("wrap_drain");

        // Random traffic: 1-in-3 writes, 50% ready; writes held off while the
        // outstanding count could make the buffer full, so nothing may drop.
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && exp_q.size() < DEPTH) begin
                afe_valid_i = 1'b1;
                afe_data_i  = $urandom;
                exp_q.push_back(afe_data_i);
                sent++;
            end else begin
                afe_valid_i = 1'b0;
            end
            step();
        end
        afe_valid_i = 1'b0;
        check("rand_sent", sent, 1000);
        drain("rand_drain");
        step();
        @(negedge clk_i);
        check("rand_no_ovf", ovf_o, 0);
        check("rand_fill0", fill_o, 0);
        check("rand_out_empty", out_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
